flasher_sequencer: RTL and testbench

- Self-contained sequencer for the 16-lamp bound flasher.
- Owns the lamp-count register, the state register, the tick prescaler and flick input conditioning.
- Steps the lit-lamp bar one position per tick through the fixed up/down pattern.
- Honours flick kickback requests at defined checkpoints.
- Sits between the board button/clock and the lamp output pins; all system sequencing is decided here.

---
 rtl/flasher_sequencer.sv | 170 +++++++++++++++++
 tb/tb_flasher_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flasher_sequencer.sv
// flasher_sequencer: 16-lamp bound flasher sequencer.
// Owns the tick prescaler, the flick synchronizer and kickback latch, the
// lamp-count register and the sequence state register.
module flasher_sequencer #(
    parameter int unsigned DIV_CNT      = 4,
    parameter bit          STICKY_FLICK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flick,
    output logic [15:0] lamp,
    output logic [2:0]  state,
    output logic        tick,
    output logic        busy
);

    localparam int unsigned PRE_W    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned LAMP_N   = 16;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(16);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_5    = CNT_W'(5);
    localparam logic [CNT_W-1:0] CNT_6    = CNT_W'(6);
    localparam logic [CNT_W-1:0] CNT_11   = CNT_W'(11);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        UP_0_15    = 3'd1,
        DN_15_5    = 3'd2,
        UP_5_10    = 3'd3,
        DN_10_0    = 3'd4,
        UP_0_5     = 3'd5,
        DN_5_0     = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_inc, count_dec;
    logic [PRE_W-1:0]   presc_q;
    logic               sync1_q, flick_s, flick_prev_q;
    logic               pending_q, pending_d;
    logic               tick_c, f_eff, decision;

    assign tick_c    = (presc_q == PRE_LAST);
    assign f_eff     = STICKY_FLICK ? (pending_q | flick_s) : flick_s;
    assign count_inc = count_q + CNT_ONE;
    assign count_dec = count_q - CNT_ONE;

    // Free-running tick prescaler, wraps at DIV_CNT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick_c) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Two-flop flick synchronizer, edge history and kickback latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            flick_s      <= 1'b0;
            flick_prev_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            sync1_q      <= flick;
            flick_s      <= sync1_q;
            flick_prev_q <= flick_s;
            pending_q    <= pending_d;
        end
    end

    // Kickback latch: a decision tick always clears, and wins over a new edge.
    always_comb begin
        pending_d = pending_q;
        if (decision) begin
            pending_d = 1'b0;
        end else if (flick_s && !flick_prev_q) begin
            pending_d = 1'b1;
        end
    end

    // State and lamp-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and count: one bar step per tick, kickbacks at decision points.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        decision = 1'b0;
        if (state_q == ST_ILLEGAL || count_q > CNT_MAX) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else if (tick_c) begin
            case (state_q)
                IDLE: begin
                    decision = 1'b1;
                    count_d  = CNT_ZERO;
                    if (f_eff) begin
                        count_d = CNT_ONE;
                        state_d = UP_0_15;
                    end
                end
                UP_0_15: begin
                    count_d = count_inc;
                    if (count_inc == CNT_MAX) state_d = DN_15_5;
                end
                DN_15_5: begin
                    count_d = count_dec;
                    if (count_dec == CNT_5) begin
                        decision = 1'b1;
                        state_d  = f_eff ? UP_0_15 : UP_5_10;
                    end
                end
                UP_5_10: begin
                    count_d = count_inc;
                    if (count_inc == CNT_11) state_d = DN_10_0;
                end
                DN_10_0: begin
                    count_d = count_dec;
                    if (count_dec == CNT_ZERO) begin
                        decision = 1'b1;
                        state_d  = f_eff ? UP_5_10 : UP_0_5;
                    end else if (count_dec == CNT_5 && f_eff) begin
                        decision = 1'b1;
                        state_d  = UP_5_10;
                    end
                end
                UP_0_5: begin
                    count_d = count_inc;
                    if (count_inc == CNT_6) state_d = DN_5_0;
                end
                DN_5_0: begin
                    count_d = count_dec;
                    if (count_dec == CNT_ZERO) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Thermometer decode of the registered count onto the lamps.
    always_comb begin
        lamp = '0;
        for (int i = 0; i < LAMP_N; i++) begin
            lamp[i] = (CNT_W'(i) < count_q);
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);
    assign tick  = tick_c;

endmodule

// File: tb/tb_flasher_sequencer.sv
// Bench for flasher_sequencer: two instances (sticky and non-sticky flick)
// run side by side against a table-driven segment model of the bar pattern.
module tb_flasher_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flick = 1'b0;
    logic [15:0] lamp1, lamp0;
    logic [2:0]  state1, state0;
    logic        tick1, tick0, busy1, busy0;

    int errors = 0;
    int checks = 0;

    flasher_sequencer #(.DIV_CNT(DIV), .STICKY_FLICK(1'b1)) u_s1 (
        .clk(clk), .rst(rst), .flick(flick),
        .lamp(lamp1), .state(state1), .tick(tick1), .busy(busy1));

    flasher_sequencer #(.DIV_CNT(DIV), .STICKY_FLICK(1'b0)) u_s0 (
        .clk(clk), .rst(rst), .flick(flick),
        .lamp(lamp0), .state(state0), .tick(tick0), .busy(busy0));

    always #5 clk = ~clk;

    // Bar pattern as segments: seg 0 is idle, odd segments climb, even descend.
    localparam int END_CNT [7] = '{0, 16, 5, 11, 0, 6, 0};
    localparam int NEXT_F  [7] = '{0, 2, 1, 4, 3, 6, 0};
    localparam int NEXT_NF [7] = '{0, 2, 3, 4, 5, 6, 0};
    localparam bit END_DEC [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        int pre;
        bit s1;
        bit s2;
        bit prv;
        bit pend;
        int seg;
        int cnt;
    } mstate_t;

    mstate_t m1, m0;

    function automatic mstate_t model_step(mstate_t c, bit fl, bit sticky);
        mstate_t n;
        bit f;
        bit dec;
        int nc;
        n     = c;
        n.s1  = fl;
        n.s2  = c.s1;
        n.prv = c.s2;
        n.pre = (c.pre == DIV - 1) ? 0 : c.pre + 1;
        f     = sticky ? (c.pend | c.s2) : c.s2;
        dec   = 1'b0;
        if (c.pre == DIV - 1) begin
            if (c.seg == 0) begin
                dec = 1'b1;
                if (f) begin
                    n.seg = 1;
                    n.cnt = 1;
                end
            end else begin
                nc    = (c.seg % 2 == 1) ? c.cnt + 1 : c.cnt - 1;
                n.cnt = nc;
                if (c.seg == 4 && nc == 5 && f) begin
                    dec   = 1'b1;
                    n.seg = 3;
                end else if (nc == END_CNT[c.seg]) begin
                    dec   = END_DEC[c.seg];
                    n.seg = (f && END_DEC[c.seg]) ? NEXT_F[c.seg] : NEXT_NF[c.seg];
                end
            end
        end
        n.pend = dec ? 1'b0 : ((c.s2 && !c.prv) ? 1'b1 : c.pend);
        return n;
    endfunction

    function automatic logic [20:0] exp_out(mstate_t m);
        logic [31:0] bar;
        bar = (32'd1 << m.cnt) - 32'd1;
        return {bar[15:0], 3'(m.seg), (m.pre == DIV - 1), (m.seg != 0)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= '0;
            m0 <= '0;
        end else begin
            m1 <= model_step(m1, flick, 1'b1);
            m0 <= model_step(m0, flick, 1'b0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        flick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold flick across at least one tick so both instances start together.
    task automatic start_seq();
        flick = 1'b1;
        repeat (DIV + 2) @(negedge clk);
        flick = 1'b0;
    endtask

    task automatic test_reset();
        int ticks;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({lamp1, state1, tick1, busy1} !== 21'h0) begin
            errors++;
            $display("FAIL reset_s1: got %h expected 0", {lamp1, state1, tick1, busy1});
        end
        checks++;
        if ({lamp0, state0, tick0, busy0} !== 21'h0) begin
            errors++;
            $display("FAIL reset_s0: got %h expected 0", {lamp0, state0, tick0, busy0});
        end
        @(negedge clk);
        rst   = 1'b0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick1) ticks++;
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL idle_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL idle_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        checks++;
        if (ticks != 25) begin
            errors++;
            $display("FAIL tick_rate: got %0d ticks expected 25", ticks);
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        repeat ($urandom_range(0, DIV - 1)) @(negedge clk);
        flick = 1'b1;
        @(negedge clk);
        flick = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL pulse_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL pulse_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        checks++;
        if (state1 !== 3'd0 || lamp1 !== 16'h0000) begin
            errors++;
            $display("FAIL pulse_end: got state %0d lamp %h expected 0 0000", state1, lamp1);
        end
    endtask

    task automatic test_flick_held();
        bit full;
        do_reset();
        flick = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (lamp1 == 16'hFFFF) full = 1'b1;
            if (full) begin
                checks++;
                if (lamp1 < 16'h001F || lamp0 < 16'h001F) begin
                    errors++;
                    $display("FAIL held_floor cyc %0d: got %h %h expected >= 001f", i, lamp1, lamp0);
                end
            end
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL held_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL held_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        flick = 1'b0;
    endtask

    task automatic test_sticky_pulse();
        int phase;
        bit seen;
        do_reset();
        start_seq();
        phase = 0;
        seen  = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            flick = 1'b0;
            if (phase == 0 && m1.seg == 1 && m1.cnt == 12) begin
                flick = 1'b1;
                phase = 1;
            end else if (phase == 1 && m1.seg == 2) begin
                phase = 2;
            end else if (phase == 2 && m1.seg != 2) begin
                seen = 1'b1;
                checks++;
                if (state1 !== 3'd1 || lamp1 !== 16'h001F) begin
                    errors++;
                    $display("FAIL sticky_kick: got state %0d lamp %h expected 1 001f", state1, lamp1);
                end
                checks++;
                if (state0 !== 3'd3 || lamp0 !== 16'h001F) begin
                    errors++;
                    $display("FAIL nonsticky_pass: got state %0d lamp %h expected 3 001f", state0, lamp0);
                end
            end
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL stk_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL stk_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        flick = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sticky_timeout: got phase %0d expected decision reached", phase);
        end
    endtask

    task automatic test_dn10_bottom();
        int phase;
        do_reset();
        start_seq();
        phase = 0;
        for (int i = 0; i < 1200 && phase < 5; i++) begin
            @(negedge clk);
            if (phase == 0 && m1.seg == 4 && m1.cnt == 2) begin
                flick = 1'b1;
                phase = 1;
            end else if (phase == 1 && m1.seg != 4) begin
                flick = 1'b0;
                phase = 2;
                checks++;
                if (state1 !== 3'd3 || lamp1 !== 16'h0000 || state0 !== 3'd3) begin
                    errors++;
                    $display("FAIL dn10_kick: got state %0d/%0d lamp %h expected 3/3 0000", state1, state0, lamp1);
                end
            end else if (phase == 2 && m1.cnt == 1) begin
                phase = 3;
                checks++;
                if (state1 !== 3'd3 || lamp1 !== 16'h0001) begin
                    errors++;
                    $display("FAIL dn10_step: got state %0d lamp %h expected 3 0001", state1, lamp1);
                end
            end else if (phase == 3 && m1.seg == 4) begin
                phase = 4;
            end else if (phase == 4 && m1.seg != 4) begin
                phase = 5;
                checks++;
                if (state1 !== 3'd5 || state0 !== 3'd5 || lamp1 !== 16'h0000) begin
                    errors++;
                    $display("FAIL dn10_fall: got state %0d/%0d lamp %h expected 5/5 0000", state1, state0, lamp1);
                end
            end
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL dn10_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL dn10_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        flick = 1'b0;
        checks++;
        if (phase != 5) begin
            errors++;
            $display("FAIL dn10_timeout: got phase %0d expected 5", phase);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        do_reset();
        start_seq();
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            if (m1.seg == 3 && m1.cnt == 9) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_timeout: got no UP_5_10 count 9 expected reached");
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (lamp1 !== 16'h0000 || state1 !== 3'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async_s1: got lamp %h state %0d busy %b expected 0000 0 0", lamp1, state1, busy1);
        end
        checks++;
        if (lamp0 !== 16'h0000 || state0 !== 3'd0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async_s0: got lamp %h state %0d busy %b expected 0000 0 0", lamp0, state0, busy0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL rstmid_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL rstmid_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        checks++;
        if (state1 !== 3'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stay_idle: got state %0d busy %b expected 0 0", state1, busy1);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold == 0) begin
                flick = ($urandom_range(0, 3) == 0);
                hold  = flick ? $urandom_range(1, 6) : $urandom_range(1, 80);
            end
            hold--;
            checks++;
            if ({lamp1, state1, tick1, busy1} !== exp_out(m1)) begin
                errors++;
                $display("FAIL rand_s1 cyc %0d: got %h expected %h", i, {lamp1, state1, tick1, busy1}, exp_out(m1));
            end
            checks++;
            if ({lamp0, state0, tick0, busy0} !== exp_out(m0)) begin
                errors++;
                $display("FAIL rand_s0 cyc %0d: got %h expected %h", i, {lamp0, state0, tick0, busy0}, exp_out(m0));
            end
        end
        flick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_flick_held();
        test_sticky_pulse();
        test_dn10_bottom();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
